// File: rtl/vdu_mem_arbiter.sv
// rtl/vdu_mem_arbiter.sv - display RAM arbiter: VDU reads have absolute priority, CPU gets idle cycles
// Out-of-window CPU accesses complete without touching RAM; reads of them return 8'hFF.
module vdu_mem_arbiter #(
   parameter logic [15:0] BASE_ADDR = 16'h0200,
   parameter int          ADDRW     = 9
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_vdu_read_en,
   input  logic [15:0]      i_vdu_read_addr,
   output logic [7:0]       o_vdu_data,
   input  logic             i_cpu_req,
   input  logic             i_cpu_we,
   input  logic [15:0]      i_cpu_addr,
   input  logic [7:0]       i_cpu_wdata,
   output logic [7:0]       o_cpu_rdata,
   output logic             o_cpu_ack,
   output logic [ADDRW-1:0] o_mem_addr,
   output logic             o_mem_we,
   output logic [7:0]       o_mem_wdata,
   input  logic [7:0]       i_mem_rdata
);

   localparam logic [16:0]      BASE17  = {1'b0, BASE_ADDR};
   localparam logic [16:0]      LIMIT17 = BASE17 + (17'd1 << ADDRW);
   localparam logic [ADDRW-1:0] BASE_LO = BASE_ADDR[ADDRW-1:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_CPU_RD,
      S_ACK
   } state_t;

   state_t           state_q;
   logic             ack_q;
   logic [7:0]       rdata_q;
   logic [ADDRW-1:0] addr_q;
   logic [7:0]       wdata_q;

   logic             cpu_in_range;
   logic             cpu_grant;
   logic             cpu_wr_grant;
   logic [ADDRW-1:0] cpu_offset;
   logic [ADDRW-1:0] vdu_offset;
   logic [ADDRW-1:0] addr_d;
   logic [7:0]       wdata_d;
   logic             unused_vdu_hi;

   // The window never wraps, so the low bits alone give the offset modulo the RAM size.
   assign cpu_offset    = i_cpu_addr[ADDRW-1:0] - BASE_LO;
   assign vdu_offset    = i_vdu_read_addr[ADDRW-1:0] - BASE_LO;
   assign unused_vdu_hi = ^i_vdu_read_addr[15:ADDRW];

   assign cpu_in_range = ({1'b0, i_cpu_addr} >= BASE17) && ({1'b0, i_cpu_addr} < LIMIT17);
   assign cpu_grant    = (state_q == S_IDLE) && i_cpu_req && !i_vdu_read_en;
   assign cpu_wr_grant = cpu_grant && cpu_in_range && i_cpu_we;

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (i_vdu_read_en) begin
         addr_d = vdu_offset;
      end else if (cpu_grant && cpu_in_range) begin
         addr_d = cpu_offset;
      end
      if (cpu_wr_grant) begin
         wdata_d = i_cpu_wdata;
      end
   end

   // The RAM-side mux is combinational, so reset must gate it to hold the bus quiet.
   assign o_mem_addr  = i_rst_n ? addr_d : '0;
   assign o_mem_we    = i_rst_n & cpu_wr_grant;
   assign o_mem_wdata = i_rst_n ? wdata_d : 8'h00;
   assign o_vdu_data  = i_mem_rdata;
   assign o_cpu_rdata = rdata_q;
   assign o_cpu_ack   = ack_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         rdata_q <= 8'h00;
         addr_q  <= '0;
         wdata_q <= 8'h00;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_grant) begin
                  if (cpu_in_range && !i_cpu_we) begin
                     state_q <= S_CPU_RD;
                  end else begin
                     state_q <= S_ACK;
                     ack_q   <= 1'b1;
                     if (!cpu_in_range && !i_cpu_we) begin
                        rdata_q <= 8'hFF;
                     end
                  end
               end
            end
            // RAM data here belongs to the CPU address even if the VDU took the bus this cycle.
            S_CPU_RD: begin
               rdata_q <= i_mem_rdata;
               ack_q   <= 1'b1;
               state_q <= S_ACK;
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vdu_mem_arbiter.sv
// tb/tb_vdu_mem_arbiter.sv - randomized bench for vdu_mem_arbiter against a shadow-memory model
module tb_vdu_mem_arbiter;

   localparam int BASE  = 'h0200;
   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vdu_read_en;
   logic [15:0] vdu_addr;
   logic [7:0]  vdu_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic [8:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram    [0:DEPTH-1];
   logic [7:0]  shadow [0:DEPTH-1];
   logic [7:0]  exp_rdata;
   int          errors = 0;
   int          checks = 0;

   vdu_mem_arbiter #(.BASE_ADDR(16'h0200), .ADDRW(9)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_vdu_read_en(vdu_read_en), .i_vdu_read_addr(vdu_addr), .o_vdu_data(vdu_data),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, one-cycle read latency; loaded from the model image while in reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= shadow[i];
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (vdu_read_en && mem_we) begin
            errors++;
            $display("FAIL we_during_vdu: mem_we=%0b while vdu_read_en=1, required 0", mem_we);
         end
      end
   end

   function automatic logic in_rng(input logic [15:0] a);
      return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
   endfunction

   function automatic int off(input logic [15:0] a);
      return int'(a) - BASE;
   endfunction

   task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] wd);
      logic exp_we;
      int   exp_lat;
      int   lat;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      @(negedge clk);
      exp_we = we && in_rng(a);
      checks++;
      if (mem_we !== exp_we) begin
         errors++; $display("FAIL grant_we addr=%h: got %0b, required %0b", a, mem_we, exp_we);
      end
      if (in_rng(a)) begin
         checks++;
         if (int'(mem_addr) != off(a)) begin
            errors++; $display("FAIL grant_addr addr=%h: got %0d, required %0d", a, mem_addr, off(a));
         end
      end
      if (exp_we) begin
         checks++;
         if (mem_wdata !== wd) begin
            errors++; $display("FAIL grant_wdata: got %h, required %h", mem_wdata, wd);
         end
         shadow[off(a)] = wd;
      end
      if (!we) exp_rdata = in_rng(a) ? shadow[off(a)] : 8'hFF;
      exp_lat = (!we && in_rng(a)) ? 2 : 1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!cpu_ack && lat < 8);
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL ack_latency addr=%h we=%0b: got %0d, required %0d", a, we, lat, exp_lat);
      end
      checks++;
      if (cpu_rdata !== exp_rdata) begin
         errors++; $display("FAIL cpu_rdata addr=%h: got %h, required %h", a, cpu_rdata, exp_rdata);
      end
      if (in_rng(a)) begin
         checks++;
         if (int'(mem_addr) != off(a) || mem_we !== 1'b0) begin
            errors++; $display("FAIL addr_hold: got addr=%0d we=%0b, required addr=%0d we=0", mem_addr, mem_we, off(a));
         end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0) begin
         errors++; $display("FAIL ack_width: ack=%0b one cycle after ack, required 0", cpu_ack);
      end
   endtask

   task automatic vdu_read_check(input logic [15:0] a);
      @(posedge clk); #1;
      vdu_read_en = 1'b1; vdu_addr = a;
      @(negedge clk);
      checks++;
      if (int'(mem_addr) != off(a) || mem_we !== 1'b0) begin
         errors++; $display("FAIL vdu_grant addr=%h: got addr=%0d we=%0b, required %0d we=0", a, mem_addr, mem_we, off(a));
      end
      @(posedge clk); #1;
      vdu_read_en = 1'b0;
      @(negedge clk);
      checks++;
      if (vdu_data !== shadow[off(a)]) begin
         errors++; $display("FAIL vdu_data addr=%h: got %h, required %h", a, vdu_data, shadow[off(a)]);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00 || mem_we !== 1'b0 || mem_addr !== 9'd0 || mem_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: ack=%0b rdata=%h we=%0b addr=%0d wdata=%h, required all zero",
                  cpu_ack, cpu_rdata, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      vdu_read_en = 1'b0; cpu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: ack=%0b we=%0b, required 0 0", cpu_ack, mem_we);
      end
   endtask

   task automatic test_write_read();
      cpu_access(1'b1, 16'h0205, 8'h5A);
      vdu_read_check(16'h0205);
      cpu_access(1'b0, 16'h0205, 8'h00);
   endtask

   task automatic test_out_of_range();
      cpu_access(1'b0, 16'h0100, 8'h00);
      cpu_access(1'b1, 16'h0400, 8'hC3);
      cpu_access(1'b1, 16'h01FF, 8'h3C);
      cpu_access(1'b0, 16'h01FF, 8'h00);
      cpu_access(1'b0, 16'hFFFF, 8'h00);
      cpu_access(1'b1, 16'h0200, 8'h11);
      cpu_access(1'b1, 16'h03FF, 8'h22);
      cpu_access(1'b0, 16'h03FF, 8'h00);
      cpu_access(1'b0, 16'h0200, 8'h00);
      cpu_access(1'b0, 16'h0400, 8'h00);
   endtask

   task automatic test_contention();
      logic [7:0] wd;
      wd = 8'($urandom);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = wd;
      vdu_read_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         vdu_addr = 16'(BASE + $urandom_range(DEPTH - 1, 0));
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0 || cpu_ack !== 1'b0 || int'(mem_addr) != off(vdu_addr)) begin
            errors++;
            $display("FAIL contention cycle %0d: we=%0b ack=%0b addr=%0d, required 0 0 %0d",
                     i, mem_we, cpu_ack, mem_addr, off(vdu_addr));
         end
         @(posedge clk); #1;
      end
      vdu_read_en = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 9'h100 || mem_wdata !== wd) begin
         errors++;
         $display("FAIL contention_grant: we=%0b addr=%h wdata=%h, required 1 100 %h", mem_we, mem_addr, mem_wdata, wd);
      end
      shadow['h100] = wd;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b1) begin
         errors++; $display("FAIL contention_ack: ack=%0b, required 1", cpu_ack);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      vdu_read_check(16'h0300);
   endtask

   task automatic test_vdu_during_cpu_rd();
      logic [15:0] a;
      logic [15:0] v;
      a = 16'(BASE + $urandom_range(DEPTH - 1, 0));
      v = 16'(BASE + $urandom_range(DEPTH - 1, 0));
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      @(negedge clk);
      @(posedge clk); #1;
      vdu_read_en = 1'b1; vdu_addr = v;
      @(negedge clk);
      checks++;
      if (int'(mem_addr) != off(v) || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL cpurd_vdu_addr: addr=%0d ack=%0b, required %0d 0", mem_addr, cpu_ack, off(v));
      end
      @(negedge clk);
      exp_rdata = shadow[off(a)];
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== exp_rdata) begin
         errors++; $display("FAIL cpurd_data: ack=%0b rdata=%h, required 1 %h", cpu_ack, cpu_rdata, exp_rdata);
      end
      checks++;
      if (vdu_data !== shadow[off(v)]) begin
         errors++; $display("FAIL cpurd_vdu_data: got %h, required %h", vdu_data, shadow[off(v)]);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; vdu_read_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] wd;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0210;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      exp_rdata = 8'h00;
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00 || mem_we !== 1'b0 || mem_addr !== 9'd0) begin
         errors++;
         $display("FAIL midreset_outputs: ack=%0b rdata=%h we=%0b addr=%0d, required 0 00 0 0", cpu_ack, cpu_rdata, mem_we, mem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (cpu_ack !== 1'b0) begin
            errors++; $display("FAIL midreset_ack: ack=%0b during reset, required 0", cpu_ack);
         end
      end
      wd = 8'($urandom);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0277; cpu_wdata = wd;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || cpu_ack !== 1'b0 || mem_addr !== 9'h077) begin
         errors++; $display("FAIL first_grant_after_reset: we=%0b ack=%0b addr=%h, required 1 0 077", mem_we, cpu_ack, mem_addr);
      end
      shadow['h077] = wd;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h00) begin
         errors++; $display("FAIL after_reset_ack: ack=%0b rdata=%h, required 1 00", cpu_ack, cpu_rdata);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] d1;
      logic [7:0] d2;
      d1 = 8'($urandom);
      d2 = ~d1;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0333; cpu_wdata = d1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== d1) begin
         errors++; $display("FAIL b2b_first: we=%0b wdata=%h, required 1 %h", mem_we, mem_wdata, d1);
      end
      @(posedge clk); #1;
      cpu_wdata = d2;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL b2b_ack1: ack=%0b we=%0b, required 1 0", cpu_ack, mem_we);
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== d2 || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL b2b_second: we=%0b wdata=%h ack=%0b, required 1 %h 0", mem_we, mem_wdata, cpu_ack, d2);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b1) begin
         errors++; $display("FAIL b2b_ack2: ack=%0b, required 1", cpu_ack);
      end
      shadow['h133] = d2;
      vdu_read_check(16'h0333);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(2, 0) == 0) begin
            vdu_read_check(16'(BASE + $urandom_range(DEPTH - 1, 0)));
         end else begin
            cpu_access(1'($urandom), 16'($urandom_range('h0410, 'h01F0)), 8'($urandom));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      vdu_read_en = 1'b1; vdu_addr = 16'h0205;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0205; cpu_wdata = 8'hA5;
      exp_rdata = 8'h00;
      for (int i = 0; i < DEPTH; i++) shadow[i] = 8'($urandom);
      test_reset();
      test_write_read();
      test_out_of_range();
      test_contention();
      test_vdu_during_cpu_rd();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
